// File: rtl/poisson_frame_writer.sv
// Rate-encodes ROW 8-bit intensities into spike frames and streams WIDTH
// consecutive frames into the raster memory write port as one gap-free burst.
module poisson_frame_writer #(
  parameter int          ROW       = 19,
  parameter int          WIDTH     = 128,
  parameter int          LOG_WIDTH = 7,
  parameter int          IDX_W     = 5,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           pix_valid,
  output logic           pix_ready,
  input  logic [7:0]     pix_data,
  input  logic           start,
  input  logic           clear,
  output logic           mem_we,
  output logic [ROW-1:0] mem_data,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOADED = 2'd1,
    S_BURST  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [LOG_WIDTH-1:0] k_q, k_d;
  logic [7:0]           inten_q [ROW];
  logic [7:0]           inten_d [ROW];
  logic                 mem_we_q, mem_we_d;
  logic [ROW-1:0]       mem_data_q, mem_data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [15:0]          frame_src_s;
  logic [ROW-1:0]       frame_s;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [7:0] rnd_byte(input logic [15:0] v, input logic [3:0] s);
    logic [31:0] dbl;
    dbl = {v, v} >> s;
    return dbl[7:0];
  endfunction

  // Spike frame: the entry edge uses SEED directly because lfsr_q is being reloaded that cycle.
  always_comb begin
    frame_src_s = (state_q == S_BURST) ? lfsr_q : SEED;
    frame_s     = '0;
    for (int r = 0; r < ROW; r++) begin
      frame_s[r] = (rnd_byte(frame_src_s, 4'(r % 16)) < inten_q[r]);
    end
  end

  // Next-state and registered-output decode; clear overrides everything.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lfsr_d     = lfsr_q;
    k_d        = k_q;
    inten_d    = inten_q;
    mem_we_d   = 1'b0;
    mem_data_d = '0;
    done_d     = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pix_valid) begin
            for (int r = 0; r < ROW; r++) begin
              if (idx_q == IDX_W'(r)) begin
                inten_d[r] = pix_data;
              end else begin
                inten_d[r] = inten_q[r];
              end
            end
            if (idx_q == IDX_W'(ROW - 1)) begin
              state_d = S_LOADED;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            idx_d = idx_q;
          end
        end
        S_LOADED: begin
          if (start) begin
            state_d    = S_BURST;
            lfsr_d     = lfsr_next(SEED);
            k_d        = '0;
            mem_we_d   = 1'b1;
            mem_data_d = frame_s;
          end else begin
            state_d = S_LOADED;
          end
        end
        S_BURST: begin
          // k_q is the index of the frame currently on mem_data; lfsr_q already leads by one step.
          if (k_q == LOG_WIDTH'(WIDTH - 1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            mem_we_d   = 1'b1;
            mem_data_d = frame_s;
            lfsr_d     = lfsr_next(lfsr_q);
            k_d        = k_q + LOG_WIDTH'(1);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      endcase
    end
    busy_d = mem_we_d;
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      lfsr_q     <= SEED;
      k_q        <= '0;
      mem_we_q   <= 1'b0;
      mem_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lfsr_q     <= lfsr_d;
      k_q        <= k_d;
      mem_we_q   <= mem_we_d;
      mem_data_q <= mem_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Intensity storage; contents are only meaningful after a full load.
  always_ff @(posedge clk) begin
    inten_q <= inten_d;
  end

  assign pix_ready = (state_q == S_IDLE);
  assign mem_we    = mem_we_q;
  assign mem_data  = mem_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_poisson_frame_writer.sv
// Scoreboard bench for poisson_frame_writer: stimulus pushes expected frames,
// a negedge monitor pops and compares whatever the DUT writes.
module tb_poisson_frame_writer;
  localparam int          ROW   = 19;
  localparam int          WIDTH = 128;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic           clk = 1'b0;
  logic           rstn;
  logic           pix_valid;
  logic           pix_ready;
  logic [7:0]     pix_data;
  logic           start;
  logic           clear;
  logic           mem_we;
  logic [ROW-1:0] mem_data;
  logic           busy;
  logic           done;

  poisson_frame_writer dut (
    .clk(clk), .rstn(rstn), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .start(start), .clear(clear), .mem_we(mem_we),
    .mem_data(mem_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit             is_done;
    int             k;
    logic [ROW-1:0] data;
  } exp_t;

  exp_t           sb[$];
  exp_t           mon_e;
  int             tests = 0;
  int             fails = 0;
  int             cyc = 0;
  int             start_cyc = 0;
  int             bit0_cnt = 0;
  int             mdl_bit0 = 0;
  logic [ROW-1:0] first_frame;
  logic [7:0]     mdl_int [ROW];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every DUT write or done pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (mem_we || done) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 1'b0, {30'd0, mem_we, done}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("kind_done", done === mon_e.is_done, {31'd0, done}, {31'd0, mon_e.is_done});
        chk("kind_we", mem_we === !mon_e.is_done, {31'd0, mem_we}, {31'd0, !mon_e.is_done});
        if (!mon_e.is_done) begin
          chk("frame_data", mem_data === mon_e.data, 32'(mem_data), 32'(mon_e.data));
          if (mon_e.k == 0) first_frame = mem_data;
          if (mem_data[0]) bit0_cnt++;
        end
        chk("timing", cyc == start_cyc + 1 + mon_e.k, cyc, start_cyc + 1 + mon_e.k);
      end
    end
    if (!mem_we) chk("idle_data_zero", mem_data === '0, 32'(mem_data), 32'd0);
    chk("busy_eq_we", busy === mem_we, {31'd0, busy}, {31'd0, mem_we});
  end

  function automatic logic [15:0] mdl_next(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

  task automatic push_burst(input int n, input bit full);
    logic [15:0]    l;
    logic [7:0]     rnd;
    logic [ROW-1:0] f;
    exp_t           e;
    l = SEED;
    mdl_bit0 = 0;
    for (int k = 0; k < n; k++) begin
      for (int r = 0; r < ROW; r++) begin
        for (int b = 0; b < 8; b++) rnd[b] = l[(b + (r % 16)) % 16];
        f[r] = (rnd < mdl_int[r]);
      end
      mdl_bit0 += int'(f[0]);
      e.is_done = 1'b0; e.k = k; e.data = f;
      sb.push_back(e);
      l = mdl_next(l);
    end
    if (full) begin
      e.is_done = 1'b1; e.k = WIDTH; e.data = '0;
      sb.push_back(e);
    end
  endtask

  task automatic load_row();
    for (int i = 0; i < ROW; i++) begin
      pix_data  = mdl_int[i];
      pix_valid = 1'b1;
      @(negedge clk);
    end
    pix_valid = 1'b0;
    chk("loaded_not_ready", pix_ready === 1'b0, {31'd0, pix_ready}, 32'd0);
  endtask

  task automatic pulse_start();
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(name, sb.size() == 0, sb.size(), 32'd0);
  endtask

  task automatic check_quiet(input string name);
    chk({name, "_we"}, mem_we === 1'b0, {31'd0, mem_we}, 32'd0);
    chk({name, "_busy"}, busy === 1'b0, {31'd0, busy}, 32'd0);
    chk({name, "_done"}, done === 1'b0, {31'd0, done}, 32'd0);
    chk({name, "_ready"}, pix_ready === 1'b1, {31'd0, pix_ready}, 32'd1);
  endtask

  task automatic full_burst(input string name);
    load_row();
    push_burst(WIDTH, 1'b1);
    pulse_start();
    wait_drain({name, "_drain"});
    @(negedge clk);
    #1;
    check_quiet({name, "_after"});
  endtask

  initial begin
    int acc;
    rstn = 1'b0; pix_valid = 1'b0; pix_data = 8'd0; start = 1'b0; clear = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    rstn = 1'b1;
    @(negedge clk);

    // All-zero intensities; stray start in IDLE must do nothing.
    pulse_start();
    repeat (3) @(negedge clk);
    for (int r = 0; r < ROW; r++) mdl_int[r] = 8'h00;
    full_burst("zero");

    // Row 0 saturated: frame 0 bit 0 spikes (0xE1 < 0xFF), others never.
    for (int r = 0; r < ROW; r++) mdl_int[r] = 8'h00;
    mdl_int[0] = 8'hFF;
    full_burst("sat");
    chk("sat_frame0", first_frame === 19'h00001, 32'(first_frame), 32'h1);

    // Row 0 at half scale: frame 0 bit 0 silent, spike count near half.
    mdl_int[0] = 8'h80;
    bit0_cnt = 0;
    full_burst("half");
    chk("half_frame0", first_frame === 19'h00000, 32'(first_frame), 32'h0);
    chk("half_count_model", bit0_cnt == mdl_bit0, bit0_cnt, mdl_bit0);
    chk("half_count_range", bit0_cnt >= 48 && bit0_cnt <= 80, bit0_cnt, 32'd64);

    // pix_valid held for 25 beats with start on the final accepted beat.
    acc = 0;
    for (int i = 0; i < 25; i++) begin
      pix_data  = 8'(i * 11 + 3);
      pix_valid = 1'b1;
      start     = (i == ROW - 1);
      if (pix_ready) acc++;
      if (i < ROW) mdl_int[i] = 8'(i * 11 + 3);
      @(negedge clk);
    end
    pix_valid = 1'b0;
    start     = 1'b0;
    chk("beats_accepted", acc == ROW, acc, ROW);
    chk("held_not_ready", pix_ready === 1'b0, {31'd0, pix_ready}, 32'd0);
    repeat (3) @(negedge clk);
    push_burst(WIDTH, 1'b1);
    pulse_start();
    wait_drain("held_drain");
    @(negedge clk);
    #1;
    check_quiet("held_after");

    // clear at frame 40, then a fresh burst must restart from SEED.
    for (int r = 0; r < ROW; r++) mdl_int[r] = 8'(r * 14);
    load_row();
    push_burst(40, 1'b0);
    pulse_start();
    wait_drain("clear_drain");
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    check_quiet("clear");
    repeat (3) @(negedge clk);
    full_burst("post_clear");

    // Reset at frame 10, then a full burst after release.
    load_row();
    push_burst(10, 1'b0);
    pulse_start();
    wait_drain("rst_drain");
    rstn = 1'b0;
    @(negedge clk);
    #1;
    check_quiet("rst_mid");
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    full_burst("post_rst");

    repeat (3) @(negedge clk);
    chk("final_empty", sb.size() == 0, sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
